// File: rtl/wb_pkg.sv
// Shared types for the write-back buffer: FSM states and the buffer entry layout.
package wb_pkg;

   localparam int S_OFFSET = 5;
   localparam int S_LINE   = 8 * (2 ** S_OFFSET);
   localparam int TAG_W    = 32 - S_OFFSET;

   typedef enum logic [1:0] {
      IDLE,
      RD_MISS,
      DRAIN,
      RESP
   } wb_state_t;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [S_LINE-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_buffer_if.sv
// Cache-side and pmem-side line ports of the write-back buffer.
interface writeback_buffer_if #(
   parameter int s_line = 256
);
   logic [31:0]       mem_address;
   logic              mem_read;
   logic              mem_write;
   logic [s_line-1:0] mem_wdata;
   logic [s_line-1:0] mem_rdata;
   logic              mem_resp;

   logic [31:0]       pmem_address;
   logic              pmem_read;
   logic              pmem_write;
   logic [s_line-1:0] pmem_wdata;
   logic [s_line-1:0] pmem_rdata;
   logic              pmem_resp;

   // slave is the buffer's view; master is the cache/pmem environment
   modport slave (
      input  mem_address, mem_read, mem_write, mem_wdata,
      output mem_rdata, mem_resp,
      output pmem_address, pmem_read, pmem_write, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output mem_address, mem_read, mem_write, mem_wdata,
      input  mem_rdata, mem_resp,
      input  pmem_address, pmem_read, pmem_write, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/wb_match.sv
// Fully associative tag lookup: one-hot hit vector plus encoded index of the hit.
module wb_match
   import wb_pkg::*;
#(
   parameter int s_depth = 2
) (
   input  logic [2**s_depth-1:0] valids,
   input  logic [TAG_W-1:0]      tags [2**s_depth],
   input  logic [TAG_W-1:0]      tag,
   output logic [2**s_depth-1:0] hit_vec,
   output logic [s_depth-1:0]    hit_idx
);

   always_comb begin
      hit_vec = '0;
      hit_idx = '0;
      for (int i = 0; i < 2 ** s_depth; i++) begin
         if (valids[i] && (tags[i] == tag)) begin
            hit_vec[i] = 1'b1;
            hit_idx    = i[s_depth-1:0];
         end
      end
   end

endmodule

// File: rtl/writeback_buffer.sv
// Write-back buffer: absorbs dirty evictions into a small associative FIFO,
// serves read hits locally and drains lines to pmem in the background.
module writeback_buffer
   import wb_pkg::*;
#(
   parameter int s_offset     = S_OFFSET,
   parameter int s_line       = S_LINE,
   parameter int s_depth      = 2,
   parameter int drain_thresh = 1
) (
   input  logic              clk,
   input  logic              rst,
   writeback_buffer_if.slave bus,
   output logic [23:0]       hit_counter,
   output logic [23:0]       miss_counter
);

   localparam int n_entries = 2 ** s_depth;
   localparam logic [s_depth:0] full_count   = (s_depth + 1)'(n_entries);
   localparam logic [s_depth:0] thresh_count = (s_depth + 1)'(drain_thresh);

   wb_state_t             state, state_next;
   wb_entry_t             entries [n_entries];
   logic [n_entries-1:0]  valids;
   logic [TAG_W-1:0]      tags [n_entries];
   logic [n_entries-1:0]  hit_vec;
   logic [s_depth-1:0]    hit_idx;
   logic [s_depth-1:0]    head, tail;
   logic [s_depth:0]      count;
   logic                  hit, full;
   logic [TAG_W-1:0]      line_tag;
   logic [s_line-1:0]     rdata_q, pwdata_q;
   logic [31:0]           paddr_q;

   function automatic logic [23:0] sat_inc(input logic [23:0] v);
      return (v == 24'hFFFFFF) ? v : v + 24'd1;
   endfunction

   assign line_tag = bus.mem_address[31:s_offset];
   assign full     = (count == full_count);
   assign hit      = |hit_vec;

   always_comb begin
      for (int i = 0; i < n_entries; i++) begin
         valids[i] = entries[i].valid;
         tags[i]   = entries[i].tag;
      end
   end

   wb_match #(.s_depth(s_depth)) u_match (
      .valids (valids),
      .tags   (tags),
      .tag    (line_tag),
      .hit_vec(hit_vec),
      .hit_idx(hit_idx)
   );

   // A pending request always beats an idle drain; a full-buffer write drains first.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.mem_read)
               state_next = hit ? RESP : RD_MISS;
            else if (bus.mem_write)
               state_next = (hit || !full) ? RESP : DRAIN;
            else if (count >= thresh_count)
               state_next = DRAIN;
         end
         RD_MISS: if (bus.pmem_resp) state_next = RESP;
         DRAIN:   if (bus.pmem_resp) state_next = IDLE;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         hit_counter  <= '0;
         miss_counter <= '0;
         rdata_q      <= '0;
         pwdata_q     <= '0;
         paddr_q      <= '0;
         for (int i = 0; i < n_entries; i++) entries[i].valid <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (bus.mem_read) begin
                  if (hit) begin
                     rdata_q     <= entries[hit_idx].data;
                     hit_counter <= sat_inc(hit_counter);
                  end else begin
                     miss_counter <= sat_inc(miss_counter);
                     paddr_q      <= {line_tag, {s_offset{1'b0}}};
                  end
               end else if (bus.mem_write) begin
                  if (hit) begin
                     entries[hit_idx].data <= bus.mem_wdata;
                  end else if (!full) begin
                     entries[tail] <= '{valid: 1'b1, tag: line_tag, data: bus.mem_wdata};
                     tail          <= tail + 1'b1;
                     count         <= count + 1'b1;
                  end else begin
                     paddr_q  <= {entries[head].tag, {s_offset{1'b0}}};
                     pwdata_q <= entries[head].data;
                  end
               end else if (count >= thresh_count) begin
                  paddr_q  <= {entries[head].tag, {s_offset{1'b0}}};
                  pwdata_q <= entries[head].data;
               end
            end
            RD_MISS: if (bus.pmem_resp) rdata_q <= bus.pmem_rdata;
            DRAIN: begin
               if (bus.pmem_resp) begin
                  entries[head].valid <= 1'b0;
                  head                <= head + 1'b1;
                  count               <= count - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_resp     = (state == RESP);
   assign bus.pmem_read    = (state == RD_MISS);
   assign bus.pmem_write   = (state == DRAIN);
   assign bus.mem_rdata    = rdata_q;
   assign bus.pmem_address = paddr_q;
   assign bus.pmem_wdata   = pwdata_q;

endmodule
